// File: rtl/rs_sched_pkg.sv
// rs_sched_pkg: shared entry-state encoding and default sizes for the RS scheduler
package rs_sched_pkg;
    localparam int RS_NUM_ENTRIES = 4;
    localparam int RS_IDX_WIDTH = 2;
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_ISSUED = 2'd3
    } rs_state_e;
endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: allocation-order matrix that flags the oldest ready entry
module rs_age_matrix
    import rs_sched_pkg::*;
#(
    parameter int NUM_ENTRIES = RS_NUM_ENTRIES,
    parameter int IDX_WIDTH = RS_IDX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   alloc_fire,
    input  logic [IDX_WIDTH-1:0]   alloc_idx,
    input  logic [NUM_ENTRIES-1:0] busy,
    input  logic [NUM_ENTRIES-1:0] ready,
    output logic [NUM_ENTRIES-1:0] oldest
);
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older, older_nxt;
    // older[r][c]: r was allocated before c; the whole column is rewritten so stale bits never linger
    always_comb begin
        older_nxt = older;
        if (alloc_fire) begin
            for (int r = 0; r < NUM_ENTRIES; r++) begin
                older_nxt[r][alloc_idx] = busy[r];
                older_nxt[alloc_idx][r] = 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst || flush) older <= '0;
        else older <= older_nxt;
    end
    always_comb begin
        oldest = '0;
        for (int c = 0; c < NUM_ENTRIES; c++) begin
            oldest[c] = ready[c];
            for (int r = 0; r < NUM_ENTRIES; r++)
                if (ready[r] && older[r][c]) oldest[c] = 1'b0;
        end
    end
endmodule

// File: rtl/rs_issue_sched.sv
// rs_issue_sched: RS allocate/wake/oldest-ready issue/complete scheduler
module rs_issue_sched
    import rs_sched_pkg::*;
#(
    parameter int NUM_ENTRIES = RS_NUM_ENTRIES,
    parameter int IDX_WIDTH = RS_IDX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   alloc_valid,
    input  logic [1:0]             alloc_src_rdy,
    output logic                   alloc_ready,
    output logic [IDX_WIDTH-1:0]   alloc_idx,
    input  logic [NUM_ENTRIES-1:0] wake_a,
    input  logic [NUM_ENTRIES-1:0] wake_b,
    output logic                   issue_valid,
    output logic [IDX_WIDTH-1:0]   issue_idx,
    input  logic                   issue_ready,
    input  logic                   complete_valid,
    input  logic [IDX_WIDTH-1:0]   complete_idx,
    output logic [IDX_WIDTH:0]     count
);
    rs_state_e st [NUM_ENTRIES];
    rs_state_e st_nxt [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] op_a, op_b, op_a_nxt, op_b_nxt;
    logic [NUM_ENTRIES-1:0] free, ready, sel_mask, oldest;
    logic [IDX_WIDTH-1:0] sel_idx;
    logic alloc_fire, comp_fire, hs;
    always_comb begin
        free = '0;
        ready = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            free[i] = st[i] == ST_FREE;
            ready[i] = st[i] == ST_READY;
        end
    end
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (free[i]) alloc_idx = IDX_WIDTH'(i);
    end
    assign alloc_ready = |free;
    assign alloc_fire = alloc_valid & alloc_ready & ~flush;
    assign hs = issue_valid & issue_ready & ~flush;
    assign comp_fire = complete_valid & (st[complete_idx] == ST_ISSUED) & ~flush;
    // the entry leaving on this handshake must not be picked again for the reload
    assign sel_mask = ready & ~(NUM_ENTRIES'(hs) << issue_idx);
    rs_age_matrix #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_WIDTH(IDX_WIDTH)) u_age (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .alloc_fire(alloc_fire),
        .alloc_idx(alloc_idx),
        .busy(~free),
        .ready(sel_mask),
        .oldest(oldest)
    );
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (oldest[i]) sel_idx = IDX_WIDTH'(i);
    end
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            st_nxt[i] = st[i];
            op_a_nxt[i] = op_a[i];
            op_b_nxt[i] = op_b[i];
            case (st[i])
                ST_FREE: if (alloc_fire && alloc_idx == IDX_WIDTH'(i)) begin
                    op_a_nxt[i] = alloc_src_rdy[0];
                    op_b_nxt[i] = alloc_src_rdy[1];
                    st_nxt[i] = &alloc_src_rdy ? ST_READY : ST_WAIT;
                end
                ST_WAIT: begin
                    op_a_nxt[i] = op_a[i] | wake_a[i];
                    op_b_nxt[i] = op_b[i] | wake_b[i];
                    st_nxt[i] = op_a[i] && op_b[i] ? ST_READY : ST_WAIT;
                end
                ST_READY: st_nxt[i] = hs && issue_idx == IDX_WIDTH'(i) ? ST_ISSUED : ST_READY;
                ST_ISSUED: st_nxt[i] = comp_fire && complete_idx == IDX_WIDTH'(i) ? ST_FREE : ST_ISSUED;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) st[i] <= ST_FREE;
            op_a <= '0;
            op_b <= '0;
            issue_valid <= 1'b0;
            issue_idx <= '0;
            count <= '0;
        end else begin
            st <= st_nxt;
            op_a <= op_a_nxt;
            op_b <= op_b_nxt;
            if (!issue_valid || hs) begin
                issue_valid <= |oldest;
                issue_idx <= sel_idx;
            end
            count <= count + (IDX_WIDTH+1)'(alloc_fire) - (IDX_WIDTH+1)'(comp_fire);
        end
    end
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb_rs_issue_sched: directed stimulus checked against a timestamp-ordered entry model
module tb_rs_issue_sched;
    logic clk = 1'b0;
    logic rst, flush, alloc_valid, alloc_ready, issue_valid, issue_ready, complete_valid;
    logic [1:0] alloc_src_rdy, alloc_idx, issue_idx, complete_idx;
    logic [3:0] wake_a, wake_b;
    logic [2:0] count;
    int n_cmp = 0;
    int n_bad = 0;
    localparam int F = 0, W = 1, R = 2, I = 3;
    int m_st [4];
    bit m_a [4];
    bit m_b [4];
    int m_age [4];
    int seq = 0;
    bit m_iv = 0;
    int m_ii = 0;

    always #5 clk = ~clk;

    rs_issue_sched dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_src_rdy(alloc_src_rdy),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wake_a(wake_a), .wake_b(wake_b),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
        .complete_valid(complete_valid), .complete_idx(complete_idx),
        .count(count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: entries ordered by allocation timestamp, oldest ready = smallest stamp
    always @(posedge clk) begin
        int nst [4];
        bit na [4];
        bit nb [4];
        int ai, best;
        bit af, hs, cf;
        if (rst || flush) begin
            for (int i = 0; i < 4; i++) begin
                m_st[i] = F;
                m_a[i] = 0;
                m_b[i] = 0;
            end
            m_iv = 0;
            m_ii = 0;
        end else begin
            ai = -1;
            for (int i = 3; i >= 0; i--) if (m_st[i] == F) ai = i;
            af = alloc_valid && ai >= 0;
            hs = m_iv && issue_ready;
            cf = complete_valid && m_st[complete_idx] == I;
            best = -1;
            for (int i = 0; i < 4; i++)
                if (m_st[i] == R && !(hs && i == m_ii) && (best < 0 || m_age[i] < m_age[best])) best = i;
            for (int i = 0; i < 4; i++) begin
                nst[i] = m_st[i];
                na[i] = m_a[i];
                nb[i] = m_b[i];
                if (m_st[i] == W) begin
                    if (m_a[i] && m_b[i]) nst[i] = R;
                    na[i] = m_a[i] | wake_a[i];
                    nb[i] = m_b[i] | wake_b[i];
                end
            end
            if (af) begin
                nst[ai] = alloc_src_rdy == 2'b11 ? R : W;
                na[ai] = alloc_src_rdy[0];
                nb[ai] = alloc_src_rdy[1];
                m_age[ai] = seq;
                seq++;
            end
            if (hs) nst[m_ii] = I;
            if (cf) nst[complete_idx] = F;
            if (!m_iv || hs) begin
                m_iv = best >= 0;
                m_ii = best < 0 ? 0 : best;
            end
            for (int i = 0; i < 4; i++) begin
                m_st[i] = nst[i];
                m_a[i] = na[i];
                m_b[i] = nb[i];
            end
        end
    end

    always @(negedge clk) begin
        int busy, lf;
        if (!rst) begin
            busy = 0;
            lf = -1;
            for (int i = 3; i >= 0; i--) begin
                if (m_st[i] != F) busy++;
                else lf = i;
            end
            chk("cmp_count", 32'(count), busy);
            chk("cmp_alloc_ready", 32'(alloc_ready), 32'(lf >= 0));
            if (lf >= 0) chk("cmp_alloc_idx", 32'(alloc_idx), lf);
            chk("cmp_issue_valid", 32'(issue_valid), 32'(m_iv));
            if (m_iv) chk("cmp_issue_idx", 32'(issue_idx), m_ii);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        alloc_valid = 0;
        alloc_src_rdy = 2'b00;
        wake_a = '0;
        wake_b = '0;
        complete_valid = 0;
        complete_idx = '0;
        flush = 0;
    endtask

    task automatic alloc(input logic [1:0] src);
        alloc_valid = 1;
        alloc_src_rdy = src;
        cyc();
    endtask

    task automatic complete(input logic [1:0] idx);
        complete_valid = 1;
        complete_idx = idx;
        cyc();
    endtask

    task automatic wake(input logic [3:0] m);
        wake_a = m;
        wake_b = m;
        cyc();
    endtask

    initial begin
        rst = 1; flush = 0; alloc_valid = 0; alloc_src_rdy = 0; wake_a = 0; wake_b = 0;
        issue_ready = 0; complete_valid = 0; complete_idx = 0;
        cyc();
        cyc();
        rst = 0;
        chk("rst_alloc_ready", 32'(alloc_ready), 1);
        chk("rst_alloc_idx", 32'(alloc_idx), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_count", 32'(count), 0);
        // back-to-back fill and issue
        issue_ready = 1;
        for (int k = 0; k < 4; k++) begin
            chk("fill_alloc_idx", 32'(alloc_idx), k);
            alloc(2'b11);
            if (k > 0) chk("fill_issue_idx", 32'(issue_idx), k - 1);
        end
        chk("full_alloc_ready", 32'(alloc_ready), 0);
        chk("full_count", 32'(count), 4);
        cyc();
        chk("fill_issue_idx3", 32'(issue_idx), 3);
        cyc();
        chk("fill_drained", 32'(issue_valid), 0);
        issue_ready = 0;
        for (int i = 0; i < 4; i++) complete(2'(i));
        chk("empty_count", 32'(count), 0);
        // staggered wake: younger woken first issues first
        issue_ready = 1;
        alloc(2'b00);
        alloc(2'b00);
        wake(4'b0010);
        wake(4'b0001);
        cyc();
        chk("stagger_first", 32'(issue_idx), 1);
        cyc();
        chk("stagger_second", 32'(issue_idx), 0);
        cyc();
        chk("stagger_done", 32'(issue_valid), 0);
        complete(2'd1);
        complete(2'd0);
        // simultaneous wake: oldest issues first
        alloc(2'b00);
        alloc(2'b00);
        wake(4'b0011);
        cyc();
        cyc();
        chk("same_first", 32'(issue_idx), 0);
        cyc();
        chk("same_second", 32'(issue_idx), 1);
        cyc();
        complete(2'd0);
        complete(2'd1);
        // held issue while an older entry becomes ready
        issue_ready = 0;
        alloc(2'b00);
        alloc(2'b11);
        wake(4'b0001);
        for (int k = 0; k < 3; k++) begin
            chk("hold_idx", 32'(issue_idx), 1);
            cyc();
        end
        chk("hold_idx_last", 32'(issue_idx), 1);
        issue_ready = 1;
        cyc();
        chk("hold_then_older", 32'(issue_idx), 0);
        chk("hold_then_valid", 32'(issue_valid), 1);
        cyc();
        // full station: complete plus alloc in the same cycle
        alloc(2'b11);
        alloc(2'b11);
        cyc();
        cyc();
        issue_ready = 0;
        chk("full2_count", 32'(count), 4);
        chk("full2_alloc_ready", 32'(alloc_ready), 0);
        complete_valid = 1;
        complete_idx = 2'd2;
        alloc(2'b11);
        chk("freed_alloc_ready", 32'(alloc_ready), 1);
        chk("freed_alloc_idx", 32'(alloc_idx), 2);
        chk("freed_count", 32'(count), 3);
        // wake to FREE entry and complete to READY entry are ignored
        wake(4'b0100);
        chk("wake_free_count", 32'(count), 3);
        alloc(2'b00);
        cyc();
        cyc();
        chk("wake_free_ignored", 32'(issue_valid), 0);
        complete(2'd3);
        chk("alloc_idx_3", 32'(alloc_idx), 3);
        alloc(2'b11);
        cyc();
        complete(2'd3);
        chk("cmpl_ready_count", 32'(count), 4);
        chk("cmpl_ready_idx", 32'(issue_idx), 3);
        // flush with mixed states and a simultaneous alloc/complete/issue
        complete(2'd0);
        chk("preflush_count", 32'(count), 3);
        issue_ready = 1;
        flush = 1;
        complete_valid = 1;
        complete_idx = 2'd1;
        alloc(2'b11);
        chk("flush_count", 32'(count), 0);
        chk("flush_issue_valid", 32'(issue_valid), 0);
        chk("flush_alloc_idx", 32'(alloc_idx), 0);
        alloc(2'b11);
        cyc();
        chk("postflush_issue", 32'(issue_idx), 0);
        alloc(2'b00);
        rst = 1;
        cyc();
        rst = 0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_alloc_idx", 32'(alloc_idx), 0);
        chk("midrst_issue_valid", 32'(issue_valid), 0);
        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rs_issue_sched.md
Name: rs_issue_sched

Overview:
Scheduler for the 4-entry reservation station. It allocates free entries to dispatched instructions and tracks per-entry operand readiness from wakeup pulses. It selects the oldest ready entry for issue to the functional unit over a valid/ready handshake, and frees the entry on FU completion. It sits between the dispatch stage, the RS entry array (which supplies the wake pulses) and the functional unit.

Parameters:
NUM_ENTRIES, 4, number of RS entries
IDX_WIDTH, 2, entry index width, equal to log2(NUM_ENTRIES)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  discard all entries
alloc_valid  in  1  dispatch requests an entry
alloc_src_rdy  in  2  [0]=operand A ready at alloc, [1]=operand B ready at alloc
alloc_ready  out  1  at least one FREE entry
alloc_idx  out  IDX_WIDTH  entry that the allocation writes (lowest-index FREE)
wake_a  in  NUM_ENTRIES  per-entry operand A capture pulse
wake_b  in  NUM_ENTRIES  per-entry operand B capture pulse
issue_valid  out  1  issue request to FU
issue_idx  out  IDX_WIDTH  entry being issued
issue_ready  in  1  FU accepts
complete_valid  in  1  FU finished an entry
complete_idx  in  IDX_WIDTH  finished entry
count  out  IDX_WIDTH+1  number of non-FREE entries

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all entries FREE; op valid bits 0; age matrix 0; alloc_ready=1, alloc_idx=0, issue_valid=0, issue_idx=0, count=0.
- Per-entry states:
  - FREE -> WAIT: alloc with at least one operand not ready.
  - FREE -> READY: alloc with alloc_src_rdy=2'b11.
  - WAIT -> READY: the cycle after both op-valid bits are set.
  - READY -> ISSUED: on the issue handshake.
  - ISSUED -> FREE: on a matching complete.
- Allocation:
  - Alloc fires when alloc_valid & alloc_ready.
  - alloc_idx and alloc_ready are combinational from the registered FREE set.
  - The op-valid bits load from alloc_src_rdy.
  - When full, alloc_ready=0 and alloc_valid is ignored.
- Wake:
  - wake_a[i]/wake_b[i] set the op bit only if entry i is WAIT; ignored in every other state.
  - Wake to READY is visible to issue selection after 1 cycle.
- Age: an NxN matrix where older[i][j]=1 means i was allocated before j. On alloc of k: row k cleared, column k set for all non-FREE entries.
- Issue selection:
  - Candidate = READY entry i with no READY j where older[j][i].
  - issue_valid and issue_idx are registered. Once issue_valid=1, issue_idx is held stable until issue_ready, even if an older entry becomes READY.
  - On handshake the next selection, excluding the issued entry, loads the same cycle, so back-to-back issue runs at 1 per cycle.
- Completion:
  - complete_valid frees complete_idx only if it is ISSUED; otherwise ignored.
  - The freed entry becomes allocatable the next cycle.
- Simultaneous events: alloc, wake, issue and complete on distinct entries all take effect in the same edge. Alloc cannot target an entry being freed that cycle.
- count = non-FREE entries, updated each edge (+1 on alloc, -1 on complete, net when both occur).
- Flush: highest priority after rst. Next edge: all FREE, matrix cleared, issue_valid=0, count=0. Alloc, issue and complete in the flush cycle are discarded.
- Reset mid-operation: identical to the reset values regardless of state.

Decomposition:
- Package rs_sched_pkg: entry state encoding (FREE=0, WAIT=1, READY=2, ISSUED=3) and default NUM_ENTRIES/IDX_WIDTH.
- Sub-module rs_age_matrix: holds the age matrix, takes the alloc update plus a ready mask, and outputs a one-hot oldest-ready vector.
- Priority encoders for the free and oldest-ready vectors stay inline.

Test Plan:
- Reset, then 4 allocs with src_rdy=2'b11, issue_ready=1 -> alloc_idx 0,1,2,3; alloc_ready=0 after the fourth; count=4; issue_idx 0,1,2,3 on consecutive cycles.
- Alloc e0 and e1 with src_rdy=00; wake_a/wake_b entry1 at t, then entry0 at t+1 -> issue_idx=1 first. Repeat with both woken in the same cycle -> issue_idx=0 first (oldest).
- issue_ready held 0 for 3 cycles while an older entry becomes READY -> issue_idx stays constant until the handshake.
- Full station, complete_valid with complete_idx=2 and alloc_valid in the same cycle -> alloc ignored; the next cycle alloc_ready=1, alloc_idx=2, count=3.
- Wake pulse to a FREE entry, and complete to a READY entry -> no state change; count unchanged.
- Flush with 3 entries in mixed states plus a simultaneous alloc -> next cycle count=0, issue_valid=0, alloc_idx=0.
